// File: rtl/nanjing_pkg.sv
// Shared definitions for the Nanjing CPU-side controller: register selects,
// read-back defaults and the read-mux select encoding.
package nanjing_pkg;

    // Register select, taken from cpu_addr[10:8] inside $5xxx
    localparam logic [2:0] REG_PRG_LO   = 3'd0;
    localparam logic [2:0] REG_PROT     = 3'd1;
    localparam logic [2:0] REG_PRG_HI   = 3'd2;
    localparam logic [2:0] REG_SECURITY = 3'd3;
    localparam logic [2:0] REG_IRQ_LO   = 3'd4;
    localparam logic [2:0] REG_IRQ_HI   = 3'd5;
    localparam logic [2:0] REG_IRQ_CTL  = 3'd6;

    localparam logic [7:0] ID_DEFAULT   = 8'h04;
    localparam logic [7:0] OPEN_DEFAULT = 8'hDB;

    typedef enum logic [2:0] {
        RdId,
        RdSecurity,
        RdTrigger,
        RdPrg,
        RdOpen
    } rd_sel_e;

    function automatic rd_sel_e rd_decode(input logic [2:0] sel);
        case (sel)
            3'd0:    return RdId;
            3'd1:    return RdSecurity;
            3'd5:    return RdTrigger;
            3'd7:    return RdPrg;
            default: return RdOpen;
        endcase
    endfunction

endpackage

// File: rtl/nanjing_irq_counter.sv
// CPU-cycle IRQ down-counter with reload latch; counts on each falling M2 edge
// while enabled and raises a sticky flag on expiry.
module nanjing_irq_counter #(
    parameter int unsigned IRQ_BITS = 16
) (
    input  logic       m2_i,
    input  logic       rst_i,
    input  logic       latch_lo_we_i,
    input  logic       latch_hi_we_i,
    input  logic       ctl_we_i,
    input  logic [7:0] wdata_i,
    output logic       flag_o
);

    logic [IRQ_BITS-1:0] latch_q;
    logic [IRQ_BITS-1:0] count_q;
    logic                enable_q;
    logic                flag_q;

    always_ff @(negedge m2_i or posedge rst_i) begin
        if (rst_i) begin
            latch_q  <= '0;
            count_q  <= '0;
            enable_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            if (latch_lo_we_i) begin
                latch_q[7:0] <= wdata_i;
            end
            if (latch_hi_we_i) begin
                latch_q[IRQ_BITS-1:8] <= wdata_i[IRQ_BITS-9:0];
            end
            // A control write takes precedence over an expiry on the same edge
            if (ctl_we_i) begin
                enable_q <= wdata_i[0];
                flag_q   <= 1'b0;
                if (wdata_i[0]) begin
                    count_q <= latch_q;
                end
            end else if (enable_q) begin
                if (count_q == '0) begin
                    flag_q  <= 1'b1;
                    count_q <= latch_q;
                end else begin
                    count_q <= count_q - IRQ_BITS'(1);
                end
            end
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/nanjing_ctrl.sv
// Nanjing (mapper 163) CPU-side controller: PRG banking, protection registers,
// register read-back, WRAM/ROM strobes and a CPU-cycle IRQ counter.
module nanjing_ctrl import nanjing_pkg::*; #(
    parameter int unsigned         PRG_BITS   = 6,
    parameter logic [PRG_BITS-1:0] PRG_RESET  = 'h0F,
    parameter logic [7:0]          ID_VALUE   = ID_DEFAULT,
    parameter logic [7:0]          OPEN_VALUE = OPEN_DEFAULT,
    parameter int unsigned         IRQ_BITS   = 16
) (
    input  logic                m2,
    input  logic                rst,
    input  logic                cpu_rw,
    input  logic [15:0]         cpu_addr,
    inout  wire  [7:0]          cpu_data,
    output logic [PRG_BITS-1:0] prg_addr,
    output logic                prg_oe,
    output logic                ram_ce,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                cpu_dir,
    output logic                chr_split,
    output logic                irq_n
);

    logic [PRG_BITS-1:0] prg_q;
    logic [7:0]          security_q;
    logic [7:0]          strobe_q;
    logic                trigger_q;
    logic                chr_split_q;
    logic                irq_flag;

    logic       reg_space;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] reg_sel;
    logic [7:0] rd_data;
    logic       unused_addr;

    assign reg_space   = (cpu_addr[15:12] == 4'h5);
    assign wr_en       = ~cpu_rw & reg_space;
    assign reg_sel     = cpu_addr[10:8];
    assign unused_addr = ^{cpu_addr[11], cpu_addr[7:1]};

    always_ff @(negedge m2 or posedge rst) begin
        if (rst) begin
            prg_q       <= PRG_RESET;
            security_q  <= 8'h00;
            strobe_q    <= 8'h00;
            trigger_q   <= 1'b0;
            chr_split_q <= 1'b0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_PRG_LO: begin
                    prg_q[3:0]  <= cpu_data[3:0];
                    chr_split_q <= cpu_data[7];
                end
                REG_PROT: begin
                    if (!cpu_addr[0]) begin
                        if (cpu_data == 8'h06) begin
                            prg_q <= PRG_BITS'(3);
                        end
                    end else begin
                        // Trigger flips only on a non-zero to zero strobe transition
                        if (strobe_q != 8'h00 && cpu_data == 8'h00) begin
                            trigger_q <= ~trigger_q;
                        end
                        strobe_q <= cpu_data;
                    end
                end
                REG_PRG_HI:   prg_q[PRG_BITS-1:4] <= cpu_data[PRG_BITS-5:0];
                REG_SECURITY: security_q <= cpu_data;
                default: ;
            endcase
        end
    end

    nanjing_irq_counter #(
        .IRQ_BITS (IRQ_BITS)
    ) u_irq (
        .m2_i          (m2),
        .rst_i         (rst),
        .latch_lo_we_i (wr_en && reg_sel == REG_IRQ_LO),
        .latch_hi_we_i (wr_en && reg_sel == REG_IRQ_HI),
        .ctl_we_i      (wr_en && reg_sel == REG_IRQ_CTL),
        .wdata_i       (cpu_data),
        .flag_o        (irq_flag)
    );

    always_comb begin
        rd_data = OPEN_VALUE;
        case (rd_decode(reg_sel))
            RdId:       rd_data = ID_VALUE;
            RdSecurity: rd_data = security_q;
            RdTrigger:  rd_data = trigger_q ? security_q : 8'h00;
            RdPrg:      rd_data = 8'(prg_q);
            default:    rd_data = OPEN_VALUE;
        endcase
    end

    // Reset releases the bus immediately, even mid-read
    assign rd_en    = m2 & cpu_rw & reg_space & ~rst;
    assign cpu_data = rd_en ? rd_data : 'z;

    assign prg_oe    = ~(m2 & cpu_rw & cpu_addr[15]);
    assign cpu_dir   = prg_oe;
    assign ram_oe    = ~(m2 & cpu_rw & (cpu_addr[15:13] == 3'b011));
    assign ram_we    = ~(m2 & ~cpu_rw & (cpu_addr[15:13] == 3'b011));
    assign ram_ce    = ram_oe & ram_we;
    assign prg_addr  = prg_q;
    assign chr_split = chr_split_q;
    assign irq_n     = ~irq_flag;

endmodule
